ntt_pass_sequencer: RTL and testbench

Control stage directly upstream of butterfly_array. Runs a configured sequence of NTT passes over a two-bank coefficient memory. Per issued row it drives the bank read address and the butterfly_array controls (w_idx, mode, swap). It then replays the matching write-back address after the fixed datapath latency, and drains the pipeline between passes so that each pass reads the previous pass's results.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_pass_sequencer_if.sv | 33 +++
 rtl/wb_delay_line.sv | 35 +++
 rtl/ntt_pass_sequencer.sv | 158 +++++++++++++++
 tb/tb_ntt_pass_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared types and sizing for the NTT pass sequencer slice.
package ntt_pkg;

  localparam int unsigned LUT_SIZE   = 1360;
  localparam int unsigned ROWS       = 16;
  localparam int unsigned MAX_PASSES = 15;
  localparam int unsigned BF_LATENCY = 6;

  localparam int unsigned AW     = $clog2(ROWS);
  localparam int unsigned WIDX_W = $clog2(LUT_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fsm_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] row;
  } wb_t;

  // A run fits when the pass count is bounded and every twiddle index it touches is in the ROM.
  function automatic logic cfg_in_range(logic [4:0] num_pass, logic [WIDX_W-1:0] w_base);
    return (32'(num_pass) <= MAX_PASSES) &&
           ((32'(w_base) + 32'(num_pass) * ROWS) <= LUT_SIZE);
  endfunction

endpackage

// File: rtl/ntt_pass_sequencer_if.sv
// Host-facing control/status and butterfly_array control bundle of the pass sequencer.
interface ntt_pass_sequencer_if;
  import ntt_pkg::*;

  logic              start;
  logic [3:0]        cfg_num_stages;
  logic              cfg_mul;
  logic              cfg_swap;
  logic [WIDX_W-1:0] cfg_w_base;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [WIDX_W-1:0] w_idx;
  logic              mode;
  logic              swap;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;

  // Host side: launches runs and observes the control stream.
  modport master (
    output start, cfg_num_stages, cfg_mul, cfg_swap, cfg_w_base,
    input  busy, done, err, rd_en, rd_addr, w_idx, mode, swap, wr_en, wr_addr
  );

  // Sequencer side.
  modport slave (
    input  start, cfg_num_stages, cfg_mul, cfg_swap, cfg_w_base,
    output busy, done, err, rd_en, rd_addr, w_idx, mode, swap, wr_en, wr_addr
  );

endinterface

// File: rtl/wb_delay_line.sv
// Shift register carrying {valid, row} from read issue toward write-back.
module wb_delay_line
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH = BF_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  wb_t  din,
  output wb_t  dout,
  output logic empty
);

  wb_t [DEPTH-1:0] stage_q;

  // Shift one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], din};
    end
  end

  // Empty when no stage holds a pending write.
  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stage_q[i].valid) empty = 1'b0;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_pass_sequencer.sv
// Issues row reads and butterfly controls for a sequence of NTT passes, replays the
// write-back addresses after the datapath latency and drains between passes.
module ntt_pass_sequencer
  import ntt_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  ntt_pass_sequencer_if.slave bus
);

  fsm_t              state_q;
  logic [3:0]        pass_q;
  logic [3:0]        npass_q;
  logic              mul_q;
  logic              cfg_swap_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rd_en_q;
  logic [AW-1:0]     rd_addr_q;
  logic [WIDX_W-1:0] w_idx_q;
  logic              mode_q;
  logic              swap_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;

  logic [4:0]    num_pass;
  logic          cfg_ok;
  logic          go;
  logic          last_row;
  logic          more_passes;
  logic          next_is_final;
  logic          drain_exit;
  logic          rd_en_d;
  logic [AW-1:0] rd_addr_d;
  wb_t           dl_in;
  wb_t           dl_out;
  logic          dl_empty;

  // Decode launch, row/pass boundaries and the read that will issue at the next edge.
  always_comb begin
    num_pass      = {1'b0, bus.cfg_num_stages} + {4'b0, bus.cfg_mul};
    cfg_ok        = cfg_in_range(num_pass, bus.cfg_w_base);
    go            = (state_q == IDLE) && bus.start && cfg_ok && (num_pass != 5'd0);
    last_row      = (rd_addr_q == AW'(ROWS - 1));
    more_passes   = (4'(pass_q + 4'd1) != npass_q);
    next_is_final = (4'(pass_q + 4'd2) == npass_q);
    drain_exit    = (state_q == DRAIN) && dl_empty;
    rd_en_d       = go || ((state_q == ISSUE) && !last_row) || (drain_exit && more_passes);
    rd_addr_d     = ((state_q == ISSUE) && !last_row) ? rd_addr_q + 1'b1 : '0;
    dl_in         = '{valid: rd_en_d, row: rd_addr_d};
  end

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pass_q     <= '0;
      npass_q    <= '0;
      mul_q      <= 1'b0;
      cfg_swap_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      w_idx_q    <= '0;
      mode_q     <= 1'b0;
      swap_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= rd_en_d;
      case (state_q)
        IDLE: begin
          busy_q <= go;
          if (bus.start) begin
            if (!cfg_ok) begin
              err_q <= 1'b1;
            end else if (num_pass == 5'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              pass_q     <= '0;
              npass_q    <= num_pass[3:0];
              mul_q      <= bus.cfg_mul;
              cfg_swap_q <= bus.cfg_swap;
              rd_addr_q  <= '0;
              w_idx_q    <= bus.cfg_w_base;
              mode_q     <= bus.cfg_mul && (num_pass == 5'd1);
              swap_q     <= bus.cfg_mul && bus.cfg_swap && (num_pass == 5'd1);
            end
          end
        end
        ISSUE: begin
          if (last_row) begin
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_d;
            w_idx_q   <= w_idx_q + 1'b1;
          end
        end
        DRAIN: begin
          // Passes occupy consecutive ROM rows, so w_idx simply keeps counting.
          if (drain_exit) begin
            if (more_passes) begin
              state_q   <= ISSUE;
              pass_q    <= pass_q + 1'b1;
              rd_addr_q <= '0;
              w_idx_q   <= w_idx_q + 1'b1;
              mode_q    <= mul_q && next_is_final;
              swap_q    <= mul_q && cfg_swap_q && next_is_final;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fed with the next-cycle read so its stages line up with rd_en; the output register
  // below supplies the final cycle of latency.
  wb_delay_line #(
    .DEPTH(BF_LATENCY)
  ) u_wb_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dl_in),
    .dout (dl_out),
    .empty(dl_empty)
  );

  // Registered write-back strobe and address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q   <= dl_out.valid;
      wr_addr_q <= dl_out.row;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.w_idx   = w_idx_q;
  assign bus.mode    = mode_q;
  assign bus.swap    = swap_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Bench for ntt_pass_sequencer: directed config table, randomized configs with
// disturbances, and a mid-pass reset, all checked against a cycle-level arithmetic model.
module tb_ntt_pass_sequencer;
  import ntt_pkg::*;

  localparam int R  = int'(ROWS);
  localparam int L  = int'(BF_LATENCY);
  localparam int T  = R + L;
  localparam int MP = int'(MAX_PASSES);
  localparam int LS = int'(LUT_SIZE);

  typedef struct {
    int num;
    int mul;
    int swp;
    int base;
    int exp_err;
    int exp_done;
  } vec_t;

  typedef struct {
    logic busy;
    logic done;
    logic err;
    logic rd_en;
    int   rd_addr;
    int   w_idx;
    logic mode;
    logic swap;
    logic wr_en;
    int   wr_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ntt_pass_sequencer_if bus ();

  ntt_pass_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int c, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, req);
    end
  endtask

  // Expected outputs at cycle c (accept edge = cycle 0), from the pass/row timing rules.
  function automatic exp_t model(input int c, input int num, input int mul, input int swp,
                                 input int base);
    exp_t e;
    int p, k, r, d, cw;
    e = '{default: 0};
    p = num + mul;
    if (p > MP || base + p * R > LS) begin
      e.err = (c == 1);
      return e;
    end
    if (p == 0) begin
      e.done = (c == 1);
      return e;
    end
    d = p * T + 1;
    if (c >= 1 && c <= d) begin
      e.busy = 1'b1;
      e.done = (c == d);
      k = (c - 1) / T;
      r = (c - 1) % T;
      if (k < p && r < R) begin
        e.rd_en   = 1'b1;
        e.rd_addr = r;
        e.w_idx   = base + k * R + r;
      end
      if (k > p - 1) k = p - 1;
      e.mode = (mul != 0) && (k == p - 1);
      e.swap = e.mode && (swp != 0);
    end
    cw = c - L;
    if (cw >= 1) begin
      k = (cw - 1) / T;
      r = (cw - 1) % T;
      if (k < p && r < R) begin
        e.wr_en   = 1'b1;
        e.wr_addr = r;
      end
    end
    return e;
  endfunction

  task automatic compare_cycle(input int c, input exp_t e);
    check("busy", c, int'(bus.busy), int'(e.busy));
    check("done", c, int'(bus.done), int'(e.done));
    check("err", c, int'(bus.err), int'(e.err));
    check("rd_en", c, int'(bus.rd_en), int'(e.rd_en));
    check("wr_en", c, int'(bus.wr_en), int'(e.wr_en));
    if (e.rd_en) begin
      check("rd_addr", c, int'(bus.rd_addr), e.rd_addr);
      check("w_idx", c, int'(bus.w_idx), e.w_idx);
    end
    if (e.busy) begin
      check("mode", c, int'(bus.mode), int'(e.mode));
      check("swap", c, int'(bus.swap), int'(e.swap));
    end
    if (e.wr_en) check("wr_addr", c, int'(bus.wr_addr), e.wr_addr);
  endtask

  task automatic check_all_zero(input int c);
    check("rst_busy", c, int'(bus.busy), 0);
    check("rst_done", c, int'(bus.done), 0);
    check("rst_err", c, int'(bus.err), 0);
    check("rst_rd_en", c, int'(bus.rd_en), 0);
    check("rst_rd_addr", c, int'(bus.rd_addr), 0);
    check("rst_w_idx", c, int'(bus.w_idx), 0);
    check("rst_mode", c, int'(bus.mode), 0);
    check("rst_swap", c, int'(bus.swap), 0);
    check("rst_wr_en", c, int'(bus.wr_en), 0);
    check("rst_wr_addr", c, int'(bus.wr_addr), 0);
  endtask

  task automatic set_cfg(input int num, input int mul, input int swp, input int base);
    bus.cfg_num_stages = 4'(num);
    bus.cfg_mul        = 1'(mul);
    bus.cfg_swap       = 1'(swp);
    bus.cfg_w_base     = WIDX_W'(base);
  endtask

  // One start pulse, then a fixed-length trace compared cycle by cycle. With disturb set,
  // start and cfg are scrambled on every busy cycle before the done cycle.
  task automatic run_cfg(input int num, input int mul, input int swp, input int base,
                         input bit disturb, output int done_at, output int err_at);
    exp_t e;
    int   ncyc;
    ncyc    = (num + mul) * T + 6;
    done_at = -1;
    err_at  = -1;
    set_cfg(num, mul, swp, base);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      e = model(c, num, mul, swp, base);
      compare_cycle(c, e);
      if (bus.done && done_at < 0) done_at = c;
      if (bus.err && err_at < 0) err_at = c;
      if (disturb && e.busy && !e.done) begin
        bus.start = 1'($urandom_range(0, 1));
        set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 2047)));
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs [10];

  initial begin
    int   done_at;
    int   err_at;
    exp_t e;

    vecs[0] = '{2, 0, 0, 100, -1, 45};
    vecs[1] = '{1, 1, 1, 0, -1, 45};
    vecs[2] = '{1, 0, 0, 1350, 1, -1};
    vecs[3] = '{1, 0, 0, 1344, -1, 23};
    vecs[4] = '{0, 0, 0, 0, -1, 1};
    vecs[5] = '{0, 1, 1, 1344, -1, 23};
    vecs[6] = '{15, 0, 0, 0, -1, 331};
    vecs[7] = '{15, 1, 0, 0, 1, -1};
    vecs[8] = '{14, 1, 1, 1136, 1, -1};
    vecs[9] = '{14, 1, 1, 1120, -1, 331};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed configuration table.
    foreach (vecs[i]) begin
      run_cfg(vecs[i].num, vecs[i].mul, vecs[i].swp, vecs[i].base, 1'b0, done_at, err_at);
      check($sformatf("vec%0d_done_cycle", i), i, done_at, vecs[i].exp_done);
      check($sformatf("vec%0d_err_cycle", i), i, err_at, vecs[i].exp_err);
    end

    // Start pulses and cfg churn while busy must leave the trace untouched.
    run_cfg(2, 0, 0, 100, 1'b1, done_at, err_at);
    check("disturbed_done_cycle", 0, done_at, 45);
    run_cfg(1, 1, 1, 0, 1'b1, done_at, err_at);
    check("disturbed_mul_done_cycle", 0, done_at, 45);

    // Randomized configurations.
    for (int n = 0; n < 8; n++) begin
      run_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1400)), 1'b1,
              done_at, err_at);
    end

    // Reset during cycle 10 of the first pass.
    set_cfg(2, 0, 0, 100);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e = model(c, 2, 0, 0, 100);
      compare_cycle(c, e);
      if (c == 10) rst_n = 1'b0;
      @(posedge clk);
      #1;
    end
    check_all_zero(11);
    rst_n = 1'b1;
    for (int c = 12; c < 40; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_wr_en", c, int'(bus.wr_en), 0);
      check("post_rst_rd_en", c, int'(bus.rd_en), 0);
      check("post_rst_busy", c, int'(bus.busy), 0);
    end
    @(posedge clk);
    #1;
    run_cfg(2, 0, 0, 100, 1'b0, done_at, err_at);
    check("restart_done_cycle", 0, done_at, 45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
